// File: rtl/ec311_ver3_bcd2bin_seq_if.sv
// ---------------------------------------------------------------------------
// ec311_ver3_bcd2bin_seq_if
// Bundles the request/result signals of the sequential BCD-to-binary
// converter.
//   start    : conversion request, sampled on the rising clock edge
//   bcd_in   : packed BCD {thousands, hundreds, tens, ones}
//   bin_out  : registered 14-bit binary result
//   busy     : conversion in progress
//   done     : one-cycle pulse, bin_out has just been updated
//   err      : invalid-digit flag (only active with BCD_CHECK_EN)
// Modports: master drives requests, slave is the converter.
// ---------------------------------------------------------------------------
interface ec311_ver3_bcd2bin_seq_if;
    logic        start;
    logic [15:0] bcd_in;
    logic [13:0] bin_out;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, bcd_in,
        input  bin_out, busy, done, err
    );

    modport slave (
        input  start, bcd_in,
        output bin_out, busy, done, err
    );
endinterface

// File: rtl/ec311_ver3_bcd2bin_seq.sv
// ---------------------------------------------------------------------------
// ec311_ver3_bcd2bin_seq
// Sequential 4-digit BCD to binary converter. One digit is folded into the
// accumulator per cycle (acc = acc*10 + digit), thousands digit first.
// A conversion accepted on edge N is reported with a done pulse after edge
// N+4; busy covers the four cycles before that.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : ec311_ver3_bcd2bin_seq_if.slave (start, bcd_in, bin_out,
//            busy, done, err)
//
// Configuration macro:
//   BCD_CHECK_EN : when defined, a captured digit above 9 makes the
//                  conversion report bin_out=0 with err=1; err holds until
//                  the next accepted start. When undefined, err is tied low
//                  and out-of-range digits are used arithmetically.
// ---------------------------------------------------------------------------
module ec311_ver3_bcd2bin_seq (
    input  logic                          clk,
    input  logic                          rst_n,
    ec311_ver3_bcd2bin_seq_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] bcd_q,   bcd_d;
    logic [13:0] acc_q,   acc_d;
    logic [13:0] bin_q,   bin_d;
    logic [1:0]  idx_q,   idx_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
`ifdef BCD_CHECK_EN
    logic        bad_q,   bad_d;
    logic        err_q,   err_d;
`endif

    logic [3:0]  digit;
    logic [13:0] acc_next;

    // acc*10 + digit, built from shifts and kept to 14 bits (mod 2^14).
    function automatic logic [13:0] mac10(input logic [13:0] acc,
                                          input logic [3:0]  dig);
        logic [13:0] r;
        r = (acc << 3) + (acc << 1) + {10'd0, dig};
        return r;
    endfunction

`ifdef BCD_CHECK_EN
    function automatic logic any_bad_digit(input logic [15:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (b[i*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    assign digit    = bcd_q[{idx_q, 2'b00} +: 4];
    assign acc_next = mac10(acc_q, digit);

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        bin_d   = bin_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_CHECK_EN
        bad_d   = bad_q;
        err_d   = err_q;
`endif
        case (state_q)
            // DONE always leaves on the next edge. A start seen on that same
            // edge is taken directly so back-to-back requests run at one
            // conversion every 5 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = CONV;
                    bcd_d   = bus.bcd_in;
                    acc_d   = '0;
                    idx_d   = 2'd3;
                    busy_d  = 1'b1;
`ifdef BCD_CHECK_EN
                    bad_d   = any_bad_digit(bus.bcd_in);
                    err_d   = 1'b0;
`endif
                end
            end
            CONV: begin
                acc_d = acc_next;
                idx_d = idx_q - 2'd1;
                if (idx_q == 2'd0) begin
                    state_d = DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef BCD_CHECK_EN
                    bin_d   = bad_q ? 14'd0 : acc_next;
                    err_d   = bad_q;
`else
                    bin_d   = acc_next;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            acc_q   <= '0;
            bin_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_CHECK_EN
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            bin_q   <= bin_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_CHECK_EN
            bad_q   <= bad_d;
            err_q   <= err_d;
`endif
        end
    end

    assign bus.bin_out = bin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
`ifdef BCD_CHECK_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

endmodule

// File: tb/tb_ec311_ver3_bcd2bin_seq.sv
module tb_ec311_ver3_bcd2bin_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ec311_ver3_bcd2bin_seq_if bus ();

    ec311_ver3_bcd2bin_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    logic [13:0] last_bin = 14'd0;

    // Reference: decimal value of the four digits, mod 2^14.
    function automatic int ref_value(input logic [15:0] b);
        int v;
        v = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 +
            int'(b[7:4]) * 10 + int'(b[3:0]);
        return v % 16384;
    endfunction

    function automatic logic ref_bad(input logic [15:0] b);
        return (b[15:12] > 9) || (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a start on the next edge (edge N) and checks every cycle up to
    // and including the done cycle. glitch_k>0 re-asserts start with another
    // operand on edge N+glitch_k, which must be ignored.
    task automatic run_conv(input logic [15:0] b, input int glitch_k, input string tag);
        logic [13:0] exp_bin;
        logic        exp_err;
        exp_bin = 14'(ref_value(b));
        exp_err = 1'b0;
`ifdef BCD_CHECK_EN
        if (ref_bad(b)) begin
            exp_bin = 14'd0;
            exp_err = 1'b1;
        end
`endif
        bus.start  = 1'b1;
        bus.bcd_in = b;
        step();
        bus.start  = 1'b0;
        bus.bcd_in = 16'($urandom);
        for (int k = 1; k <= 4; k++) begin
            chk({tag, "_busy"}, {15'd0, bus.busy}, 16'd1);
            chk({tag, "_done_early"}, {15'd0, bus.done}, 16'd0);
            chk({tag, "_err_busy"}, {15'd0, bus.err}, 16'd0);
            chk({tag, "_bin_hold"}, {2'd0, bus.bin_out}, {2'd0, last_bin});
            if (k == glitch_k) begin
                bus.start  = 1'b1;
                bus.bcd_in = 16'h5678;
            end
            step();
            bus.start  = 1'b0;
            bus.bcd_in = 16'($urandom);
        end
        chk({tag, "_done"}, {15'd0, bus.done}, 16'd1);
        chk({tag, "_busy_off"}, {15'd0, bus.busy}, 16'd0);
        chk({tag, "_bin"}, {2'd0, bus.bin_out}, {2'd0, exp_bin});
        chk({tag, "_err"}, {15'd0, bus.err}, {15'd0, exp_err});
        last_bin = exp_bin;
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk({tag, "_no_done"}, {15'd0, bus.done}, 16'd0);
            chk({tag, "_no_busy"}, {15'd0, bus.busy}, 16'd0);
            chk({tag, "_bin_hold"}, {2'd0, bus.bin_out}, {2'd0, last_bin});
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.bcd_in = 16'h0000;
        #12;
        chk("rst_bin", {2'd0, bus.bin_out}, 16'd0);
        chk("rst_busy", {15'd0, bus.busy}, 16'd0);
        chk("rst_done", {15'd0, bus.done}, 16'd0);
        chk("rst_err", {15'd0, bus.err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Maximum valid value.
        run_conv(16'h9999, 0, "c9999");
        idle_check(1, "c9999");

        // Back-to-back requests at edge N+5.
        run_conv(16'h0255, 0, "c0255");
        run_conv(16'h0000, 0, "c0000");
        idle_check(1, "c0000");

        // Start during CONV must be ignored.
        run_conv(16'h1234, 2, "c1234");
        idle_check(4, "c1234");

        // Reset in the middle of a conversion.
        bus.start  = 1'b1;
        bus.bcd_in = 16'h4321;
        step();
        bus.start  = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bin", {2'd0, bus.bin_out}, 16'd0);
        chk("abort_busy", {15'd0, bus.busy}, 16'd0);
        chk("abort_done", {15'd0, bus.done}, 16'd0);
        chk("abort_err", {15'd0, bus.err}, 16'd0);
        last_bin = 14'd0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        idle_check(6, "abort");
        run_conv(16'h0010, 0, "c0010");
        idle_check(1, "c0010");

        // Invalid digits.
        run_conv(16'hFFFF, 0, "cFFFF");
        idle_check(1, "cFFFF");
        run_conv(16'h0001, 0, "c0001");
        idle_check(1, "c0001");

        // Random valid BCD with random gaps (including back-to-back).
        for (int i = 0; i < 20; i++) begin
            run_conv(rand_bcd(), 0, "rnd_bcd");
            if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3), "rnd_gap");
        end

        // Random raw 16-bit operands.
        for (int i = 0; i < 8; i++) begin
            run_conv(16'($urandom), 0, "rnd_raw");
            idle_check(1, "rnd_raw");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ec311_ver3_bcd2bin_seq.md
EC311_VER3_BCD2BIN_SEQ -- requirements
Module: ec311_ver3_bcd2bin_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  Rising-edge system clock.
REQ-003 rst_n  input  1  Asynchronous active-low reset.
REQ-004 start  input  1  Conversion request; sampled on the rising edge of clk.
REQ-005 bcd_in  input  16  Packed BCD value {thousands, hundreds, tens, ones}, 4 bits per digit; sampled with start.
REQ-006 bin_out  output  14  Registered binary result.
REQ-007 busy  output  1  High while a conversion is in progress.
REQ-008 done  output  1  Single-cycle pulse marking that bin_out was updated.
REQ-009 err  output  1  Invalid-digit flag; see Configuration.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, CONV and DONE.
REQ-011 IDLE -> CONV SHALL occur on a rising edge with start=1, called edge N.
- At edge N the block SHALL capture bcd_in, clear the accumulator, set the digit index to 3, and set busy=1.
REQ-012 CONV SHALL process one digit per cycle, from the thousands digit down to the ones digit, on edges N+1..N+4.
- Each step: acc <= (acc<<3) + (acc<<1) + digit, truncated to 14 bits.
REQ-013 At edge N+4 the block SHALL:
- load bin_out with the final accumulator;
- set done=1 and busy=0;
- enter DONE.
REQ-014 DONE -> IDLE SHALL occur unconditionally on the next edge (N+5), and done SHALL return to 0 there.
REQ-015 busy SHALL be high for exactly 4 cycles (after edges N..N+3).
REQ-016 done SHALL be high for exactly 1 cycle, giving a latency of 5 cycles from the start edge to the done cycle.
REQ-017 start SHALL be ignored in CONV and DONE; the earliest next accepted start is edge N+5, so throughput is 1 conversion per 5 cycles.
REQ-018 bcd_in changes after edge N SHALL NOT affect the result in progress.
REQ-019 bin_out SHALL hold its last value until the next done cycle.
REQ-020 Valid inputs 0x0000..0x9999 SHALL produce bin_out = 0..9999 exactly.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force:
- state=IDLE;
- bin_out=0, busy=0, done=0, err=0;
- accumulator=0 and digit index=0.
REQ-022 Reset asserted during CONV or DONE SHALL abort the conversion; no done pulse SHALL follow.
REQ-023 After rst_n is released, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-024 Macro BCD_CHECK_EN defined: at edge N the block SHALL flag any captured digit >9.
- The flagged conversion still takes 5 cycles.
- At edge N+4: bin_out=0, err=1, done=1.
- err SHALL hold until the next accepted start, which clears it at that start edge.
REQ-025 Macro BCD_CHECK_EN undefined:
- err SHALL be constant 0;
- digits >9 SHALL be used arithmetically as-is, with the result mod 2^14.

Verification
REQ-026 Reset, then start with bcd_in=0x9999 -> busy for 4 cycles, done on the 5th cycle, bin_out=9999 (0x270F).
REQ-027 Start with 0x0255, then 0x0000, back-to-back at edge N+5 -> bin_out=255, then bin_out=0, each with one done pulse.
REQ-028 Start at edge N with 0x1234; pulse start with 0x5678 at edge N+2 -> single done, bin_out=1234, second request ignored.
REQ-029 Start with 0x4321; assert rst_n=0 between edges N+2 and N+3 -> outputs 0 immediately, no done; after release, start with 0x0010 -> bin_out=10.
REQ-030 bcd_in=0xFFFF:
- BCD_CHECK_EN defined -> bin_out=0, err=1; a following start with 0x0001 clears err and gives bin_out=1.
- BCD_CHECK_EN undefined -> bin_out=281, err=0.
